mac_sum_tree: RTL and testbench
===============================

# mac_sum_tree

Parametrised successor to the four-input FIR MAC summer. It reduces NUM_MAC signed partial products from the parallel MAC lanes through a registered adder tree and holds the completed sum. The held sum is transferred to the FIR output on each 600 kHz sample strobe. Adds over the fixed summer: configurable lane count and widths, valid tracking through the tree, a stale-sample flag, and optional saturation with a sticky overflow flag.

## Interface

**Parameters**
- NUM_MAC, 4: lane count; power of two, 2..16.
- IN_W, 16: signed width of each lane input.
- OUT_W, 16: signed width of oFirOut; OUT_W ≤ IN_W+log2(NUM_MAC).

**Ports** (clock and reset first)
- iClk12M, in, 1: system clock.
- iRsn, in, 1: reset. Asynchronous, active-low.
- iEnSample600k, in, 1: single-cycle output sample strobe.
- iEnDelay, in, 1: lane data valid. Qualifies iMac in the same cycle.
- iMac, in, NUM_MAC*IN_W: packed signed lanes; lane k is bits [k*IN_W +: IN_W].
- iOvfClr, in, 1: clears oOvf.
- oFirOut, out, OUT_W: sampled FIR output, signed.
- oFirValid, out, 1: one-cycle pulse, asserted the cycle after oFirOut updates with a fresh sum.
- oStale, out, 1: set on a strobe that finds no new sum; cleared on a strobe that finds one.
- oOvf, out, 1: sticky overflow flag.

## Operation

- **Tree.** S = log2(NUM_MAC) registered levels. Level j adds adjacent pairs and grows the width by 1 bit. The final level is full precision: W = IN_W+S.
- **Pipeline advance.** Advances every clock. A valid tag shifts alongside the data, starting from iEnDelay.
- **Narrowing register.** Converts the W-bit result to OUT_W bits by keeping the low OUT_W bits. The sum is integer and no scaling is applied.
- **Hold register.** rHold loads the narrowed sum when the tag leaving the narrowing stage is 1, and sets the rNew flag.
- **Sample strobe.** On iEnSample600k:
  - If rNew is 1: oFirOut ← rHold, then rNew ← 0 and oStale ← 0.
  - If rNew is 0: oFirOut holds its value and oStale ← 1.
- **Same-cycle hold load and strobe.** The strobe samples the pre-update rHold and rNew. The new sum loads rHold with rNew=1 and waits for the next strobe.
- **Several sums between strobes.** Only the latest is kept; earlier ones are overwritten silently.
- **oFirValid.** Registered. Equals 1 in the cycle after a strobe that found rNew=1.
- **iOvfClr.** Clears oOvf. If an overflow is detected in the same cycle, setting wins.
- **Reset values.** Reset clears every register, tag and flag:
  - oFirOut = 0, oFirValid = 0, oStale = 0, oOvf = 0, rNew = 0.
- **Reset mid-operation.** All in-flight sums are discarded.

## Timing

- Lanes accepted with iEnDelay=1 at edge t are in rHold after edge t+S+1. For NUM_MAC=4 this is 3 cycles.
- A strobe at edge ≥ t+S+2 puts that sum on oFirOut. oFirValid is high in the following cycle.
- Throughput is one sum per clock. There is no backpressure.
- iEnDelay=0 cycles create bubbles. Bubbles never load rHold.

## Configuration

- **MAC_SUM_SAT_EN defined:**
  - The narrowing stage clamps the W-bit sum to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Any clamp on a valid sum sets oOvf.
- **MAC_SUM_SAT_EN undefined:**
  - The narrowing stage wraps (two's-complement truncation).
  - oOvf is tied to 0.
  - iOvfClr is ignored.

## Structure

- **Package mac_sum_pkg:**
  - clog2 function.
  - Per-level width function IN_W+j.
  - Saturation limit constants as functions of OUT_W.
- **Sub-module mac_add_stage:** one registered level. Parameters are pair count and input width. It carries the data and the valid tag. It is instantiated S times via generate.
- **Top level:** the narrowing/saturation stage, hold register and sample logic stay in mac_sum_tree.

## Test plan

All scenarios use NUM_MAC=4 and IN_W=OUT_W=16.

- **Basic sum.** Lanes 1, 2, 3, 4 with iEnDelay at edge 0 and a strobe at edge 5 → oFirOut=10 after edge 5; oFirValid high for one cycle; oStale=0.
- **Overflow, saturation build.** Lanes all 0x7000 → oFirOut=0x7FFF and oOvf=1. iOvfClr → oOvf=0.
- **Overflow, wrap build.** Lanes all 0x7000 → oFirOut=0xC000 and oOvf=0.
- **Stale and overwrite.**
  - Two strobes with no valid lanes in between → second strobe sets oStale=1 and oFirOut is unchanged.
  - Sums 5 then 9 between strobes → oFirOut=9.
- **Same-cycle collision.** Strobe in the same cycle rHold loads sum 7, with the old rHold=3 and rNew=1 → oFirOut=3. The next strobe gives 7.
- **Reset mid-operation.** Assert iRsn=0 mid-pipeline with a sum in flight → all outputs 0 asynchronously. After release, the first strobe gives oStale=1 and oFirOut=0.

Source files
------------

// File: rtl/mac_sum_pkg.sv
// Shared helpers for the MAC summing tree: level count, per-level widths and
// saturation limits (limits are used only when MAC_SUM_SAT_EN is defined).
package mac_sum_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Each tree level adds one bit of growth, so level j carries IN_W+j bits.
    function automatic int lvl_w(input int in_w, input int j);
        return in_w + j;
    endfunction

    function automatic longint sat_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/mac_add_stage.sv
// One registered adder-tree level: sums PAIRS adjacent signed pairs of IN_W
// bits into IN_W+1 bit results and carries the valid tag alongside.
module mac_add_stage #(
    parameter int PAIRS = 2,
    parameter int IN_W  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_vld,
    input  logic [2*PAIRS*IN_W-1:0]     i_data,
    output logic                        o_vld,
    output logic [PAIRS*(IN_W+1)-1:0]   o_data
);

    logic r_vld_p;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_vld_p <= 1'b0;
        else          r_vld_p <= i_vld;
    end

    assign o_vld = r_vld_p;

    for (genvar k = 0; k < PAIRS; k++) begin : g_pair
        logic signed [IN_W-1:0] w_a;
        logic signed [IN_W-1:0] w_b;
        logic signed [IN_W:0]   r_sum_p;

        assign w_a = i_data[2*k*IN_W +: IN_W];
        assign w_b = i_data[(2*k+1)*IN_W +: IN_W];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_sum_p <= '0;
            else          r_sum_p <= {w_a[IN_W-1], w_a} + {w_b[IN_W-1], w_b};
        end

        assign o_data[k*(IN_W+1) +: IN_W+1] = r_sum_p;
    end

endmodule

// File: rtl/mac_sum_tree.sv
// Registered adder tree over NUM_MAC signed MAC lanes, narrowing stage, hold
// register and 600 kHz sample output. MAC_SUM_SAT_EN selects clamp + oOvf.
module mac_sum_tree
    import mac_sum_pkg::*;
#(
    parameter int NUM_MAC = 4,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16
) (
    input  logic                      iClk12M,
    input  logic                      iRsn,
    input  logic                      iEnSample600k,
    input  logic                      iEnDelay,
    input  logic [NUM_MAC*IN_W-1:0]   iMac,
    input  logic                      iOvfClr,
    output logic [OUT_W-1:0]          oFirOut,
    output logic                      oFirValid,
    output logic                      oStale,
    output logic                      oOvf
);

    localparam int S = clog2(NUM_MAC);
    localparam int W = IN_W + S;

    for (genvar j = 0; j < S; j++) begin : g_lvl
        localparam int LW    = lvl_w(IN_W, j);
        localparam int PAIRS = NUM_MAC >> (j + 1);
        logic [PAIRS*(LW+1)-1:0] w_data;
        logic                    w_vld;

        if (j == 0) begin : g_first
            mac_add_stage #(.PAIRS(PAIRS), .IN_W(LW)) u_stage (
                .i_clk(iClk12M), .i_rst_n(iRsn),
                .i_vld(iEnDelay), .i_data(iMac),
                .o_vld(w_vld), .o_data(w_data)
            );
        end else begin : g_next
            mac_add_stage #(.PAIRS(PAIRS), .IN_W(LW)) u_stage (
                .i_clk(iClk12M), .i_rst_n(iRsn),
                .i_vld(g_lvl[j-1].w_vld), .i_data(g_lvl[j-1].w_data),
                .o_vld(w_vld), .o_data(w_data)
            );
        end
    end

    logic signed [W-1:0] w_sum;
    logic                w_sum_vld;
    assign w_sum     = g_lvl[S-1].w_data;
    assign w_sum_vld = g_lvl[S-1].w_vld;

`ifdef MAC_SUM_SAT_EN
    localparam logic signed [W-1:0] SAT_HI = W'(sat_max(OUT_W));
    localparam logic signed [W-1:0] SAT_LO = W'(sat_min(OUT_W));

    function automatic logic f_clip(input logic signed [W-1:0] x);
        return (x > SAT_HI) || (x < SAT_LO);
    endfunction

    function automatic logic signed [OUT_W-1:0] f_narrow(input logic signed [W-1:0] x);
        if (x > SAT_HI) return SAT_HI[OUT_W-1:0];
        if (x < SAT_LO) return SAT_LO[OUT_W-1:0];
        return x[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] f_narrow(input logic signed [W-1:0] x);
        return x[OUT_W-1:0];
    endfunction
`endif

    logic signed [OUT_W-1:0] r_narrow_p;
    logic                    r_vld_p;
    logic signed [OUT_W-1:0] r_hold;
    logic                    r_new;

    // Narrowing stage: last tree level -> OUT_W bits
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_narrow_p <= '0;
            r_vld_p    <= 1'b0;
        end else begin
            r_narrow_p <= f_narrow(w_sum);
            r_vld_p    <= w_sum_vld;
        end
    end

`ifdef MAC_SUM_SAT_EN
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)                          oOvf <= 1'b0;
        else if (w_sum_vld && f_clip(w_sum)) oOvf <= 1'b1;
        else if (iOvfClr)                   oOvf <= 1'b0;
    end
`else
    logic w_unused_ovfclr;
    assign w_unused_ovfclr = iOvfClr;
    assign oOvf = 1'b0;
`endif

    // Hold stage: a fresh sum always wins over the strobe clearing rNew,
    // while the strobe itself still sees the pre-update hold contents.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_hold <= '0;
            r_new  <= 1'b0;
        end else if (r_vld_p) begin
            r_hold <= r_narrow_p;
            r_new  <= 1'b1;
        end else if (iEnSample600k) begin
            r_new  <= 1'b0;
        end
    end

    // Sample stage
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            oFirOut   <= '0;
            oFirValid <= 1'b0;
            oStale    <= 1'b0;
        end else begin
            oFirValid <= iEnSample600k && r_new;
            if (iEnSample600k) begin
                if (r_new) begin
                    oFirOut <= r_hold;
                    oStale  <= 1'b0;
                end else begin
                    oStale  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_sum_tree.sv
// Self-checking bench for mac_sum_tree (NUM_MAC=4, IN_W=OUT_W=16): a
// transaction-level model checked every cycle plus hand-computed literals.
module tb_mac_sum_tree;

    localparam int NUM_MAC = 4;
    localparam int IN_W    = 16;
    localparam int OUT_W   = 16;
    localparam int S       = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    strobe;
    logic                    en;
    logic [NUM_MAC*IN_W-1:0] mac;
    logic                    ovf_clr;
    logic [OUT_W-1:0]        fir_out;
    logic                    fir_vld;
    logic                    stale;
    logic                    ovf;

    int n_tests = 0;
    int n_fail  = 0;

    mac_sum_tree #(.NUM_MAC(NUM_MAC), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .iClk12M(clk), .iRsn(rst_n), .iEnSample600k(strobe), .iEnDelay(en),
        .iMac(mac), .iOvfClr(ovf_clr), .oFirOut(fir_out), .oFirValid(fir_vld),
        .oStale(stale), .oOvf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     rdy;
        longint val;
        bit     clip;
    } ent_t;

    ent_t   pend[$];
    int     cyc = 0;
    longint m_hold = 0;
    bit     m_new = 0;
    longint m_out = 0;
    bit     m_vld = 0;
    bit     m_stale = 0;
    bit     m_ovf = 0;

    function automatic longint lane(input int k);
        logic [IN_W-1:0] v;
        v = mac[k*IN_W +: IN_W];
        return longint'($signed(v));
    endfunction

    function automatic longint narrow(input longint s, output bit clip);
        logic [63:0] t;
        logic [OUT_W-1:0] lo;
        clip = 1'b0;
`ifdef MAC_SUM_SAT_EN
        if (s > 32767)  begin clip = 1'b1; return 32767;  end
        if (s < -32768) begin clip = 1'b1; return -32768; end
        return s;
`else
        t  = s;
        lo = t[OUT_W-1:0];
        return longint'($signed(lo));
`endif
    endfunction

    always @(posedge clk) begin
        bit ovf_set;
        ovf_set = 1'b0;
        if (!rst_n) begin
            pend.delete();
            m_hold = 0; m_new = 0; m_out = 0; m_vld = 0; m_stale = 0; m_ovf = 0;
        end else begin
            m_vld = 1'b0;
            if (strobe) begin
                if (m_new) begin
                    m_out = m_hold; m_new = 0; m_stale = 0; m_vld = 1;
                end else begin
                    m_stale = 1;
                end
            end
            if (en) begin
                ent_t e;
                longint s;
                s = lane(0) + lane(1) + lane(2) + lane(3);
                e.rdy = cyc + S + 1;
                e.val = narrow(s, e.clip);
                pend.push_back(e);
            end
            foreach (pend[i]) if (pend[i].rdy - 1 == cyc && pend[i].clip) ovf_set = 1'b1;
            while (pend.size() > 0 && pend[0].rdy == cyc) begin
                m_hold = pend[0].val;
                m_new  = 1;
                void'(pend.pop_front());
            end
`ifdef MAC_SUM_SAT_EN
            if (ovf_set) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
`endif
        end
        cyc++;
        #1;
        chk("model_out", longint'($signed(fir_out)), m_out);
        chk("model_valid", fir_vld, m_vld);
        chk("model_stale", stale, m_stale);
        chk("model_ovf", ovf, m_ovf);
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit e, input logic [15:0] l0, input logic [15:0] l1,
                         input logic [15:0] l2, input logic [15:0] l3,
                         input bit stb, input bit clr);
        en = e; mac = {l3, l2, l1, l0}; strobe = stb; ovf_clr = clr;
        @(negedge clk);
        en = 1'b0; strobe = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sum1(input logic [15:0] v);
        drive(1, v, 0, 0, 0, 0, 0);
    endtask

    task automatic strobe1();
        drive(0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; strobe = 1'b0; en = 1'b0; mac = '0; ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out", fir_out, 0);
        chk("reset_valid", fir_vld, 0);
        chk("reset_stale", stale, 0);
        chk("reset_ovf", ovf, 0);
        rst_n = 1'b1;

        // Basic sum: lanes at edge 0, strobe at edge 5
        drive(1, 1, 2, 3, 4, 0, 0);
        idle(4);
        strobe1();
        chk("basic_out", longint'($signed(fir_out)), 10);
        chk("basic_valid", fir_vld, 1);
        chk("basic_stale", stale, 0);
        idle(1);
        chk("basic_valid_drop", fir_vld, 0);

        // Overflow: 4 x 0x7000 = 0x1C000
        drive(1, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 0, 0);
        idle(4);
        strobe1();
`ifdef MAC_SUM_SAT_EN
        chk("ovf_out", fir_out, 16'h7FFF);
        chk("ovf_flag", ovf, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("ovf_clr", ovf, 0);
`else
        chk("wrap_out", fir_out, 16'hC000);
        chk("wrap_ovf", ovf, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("wrap_ovf_clr", ovf, 0);
`endif

        // Stale: two strobes with no new sum
        strobe1();
        strobe1();
        chk("stale_flag", stale, 1);
`ifdef MAC_SUM_SAT_EN
        chk("stale_out", fir_out, 16'h7FFF);
`else
        chk("stale_out", fir_out, 16'hC000);
`endif
        chk("stale_valid", fir_vld, 0);

        // Overwrite: 5 then 9 before the strobe
        sum1(5);
        sum1(9);
        idle(4);
        strobe1();
        chk("overwrite_out", longint'($signed(fir_out)), 9);
        chk("overwrite_stale", stale, 0);

        // Collision: 3 sits in hold, 7 loads on the strobe edge
        sum1(3);
        sum1(7);
        idle(2);
        strobe1();
        chk("collide_first", longint'($signed(fir_out)), 3);
        strobe1();
        chk("collide_second", longint'($signed(fir_out)), 7);
        chk("collide_valid", fir_vld, 1);

        // Negative lanes
        drive(1, 16'hFFFF, 16'hFFFE, 16'h0001, 16'hFFF0, 0, 0);
        idle(4);
        strobe1();
        chk("neg_out", longint'($signed(fir_out)), -18);

        // Reset mid-pipeline
        sum1(11);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", fir_out, 0);
        chk("arst_valid", fir_vld, 0);
        chk("arst_stale", stale, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        strobe1();
        chk("post_rst_stale", stale, 1);
        chk("post_rst_out", fir_out, 0);
        chk("post_rst_valid", fir_vld, 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
